edge_slope_setup: RTL and testbench
===================================

# edge_slope_setup

Triangle-setup stage feeding the shared `UnsignedDivide` instance. It accepts three y-sorted screen-space vertices and computes the signed fixed-point inverse slope dx/dy for edges 0→1, 0→2 and 1→2. It issues up to three sequential divisions through the divider's start/ready/valid handshake, applies sign and round-to-nearest, and presents all three slopes together to the rasteriser edge walker.

## Interface
- `COORD_WIDTH`, default 8: unsigned vertex coordinate width.
- `FRAC_BITS`, default 8: fractional bits of the slope result.
- `DIV_WIDTH`, default 16: divider operand width. Must satisfy COORD_WIDTH+FRAC_BITS <= DIV_WIDTH.
- `i_clk`, in, 1: clock.
- `i_reset_n`, in, 1: reset, asynchronous, active-low.
- `i_start`, in, 1: one-cycle request. Honoured only while o_ready=1.
- `i_x0`, `i_y0`, `i_x1`, `i_y1`, `i_x2`, `i_y2`, in, COORD_WIDTH each: vertices, sampled when i_start is accepted.
- `o_ready`, out, 1: block is idle and can accept i_start.
- `o_valid`, out, 1: one-cycle pulse; results are valid.
- `o_slope01`, `o_slope02`, `o_slope12`, out, DIV_WIDTH+1 each: two's-complement dx/dy with FRAC_BITS fraction bits. Held until the next acceptance.
- `o_flat`, out, 3: bit0/1/2 is set when edge 01/02/12 has dy=0.
- `o_error`, out, 1: vertices not y-sorted.
- `o_div_start`, out, 1: one-cycle start pulse to the divider.
- `o_div_dividend`, `o_div_divisor`, out, DIV_WIDTH each: divider operands, held stable from the start pulse until the result returns.
- `i_div_ready`, `i_div_valid`, in, 1 each: divider handshake.
- `i_div_quotient`, `i_div_remainder`, in, DIV_WIDTH each: divider results.

## Operation
- **States:** IDLE, CHECK, ISSUE, WAIT, DONE. A 2-bit edge index takes the values 0=01, 1=02, 2=12.
- **IDLE:** o_ready=1.
  - i_start latches all vertices and goes to CHECK.
  - i_start in any other state is ignored.
- **CHECK:**
  - If y0>y1 or y1>y2: slopes=0, o_flat=0, o_error=1, go to DONE. No divisions are issued.
  - Otherwise: o_error=0, edge=0, go to ISSUE.
- **ISSUE, current edge (a→b):** dx = xb−xa (signed, COORD_WIDTH+1 bits); dy = yb−ya (unsigned).
  - If dy==0: slope=0, flat bit=1, advance without using the divider.
  - Otherwise, wait until i_div_ready=1, then register:
    - o_div_start=1;
    - o_div_dividend = |dx| << FRAC_BITS (zero-extended);
    - o_div_divisor = dy.
  - Then go to WAIT, with flat bit=0.
- **WAIT:** o_div_start=0. On i_div_valid:
  - mag = quotient + (2·remainder >= divisor ? 1 : 0). 2·remainder is evaluated in DIV_WIDTH+1 bits.
  - slope = (dx<0) ? −mag : mag, in DIV_WIDTH+1 bits.
  - Store the slope and advance.
- **Advance:** if edge==2 go to DONE; otherwise edge+1 and return to ISSUE.
- **DONE:** o_valid=1 for one cycle, then IDLE.
- **Ordering:** exactly one division is outstanding at a time, and edges complete in order 01, 02, 12.
- **Reset:** asserting reset at any time, including mid-division, returns the block to IDLE.
  - All outputs go to 0 except o_ready, which goes to 1.
  - Any pending divider result is discarded; the divider shares the same reset.

## Timing
- All outputs are registered. o_ready is decoded from the IDLE state register.
- **Accept:** i_start accepted at edge N; o_ready=0 from N+1; CHECK occupies cycle N+1.
- **Flat edge:** costs exactly 1 cycle in ISSUE.
- **Non-flat edge:** 1 ISSUE cycle (if i_div_ready) + cycles until i_div_valid + the WAIT cycle that consumes it.
- **Stall:** if i_div_ready=0 in ISSUE, the block stalls with no start pulse and the operand outputs unchanged.
- **Error path:** o_valid occurs 2 cycles after acceptance; o_ready returns 1 cycle after o_valid.
- **Result visibility:** slopes and flags update no later than the o_valid cycle.
- **Divider outputs:** i_div_valid outside WAIT is ignored. o_div_start is never asserted outside ISSUE→WAIT.

## Test plan
All scenarios use defaults (COORD 8, FRAC 8, DIV 16) and the real UnsignedDivide unless stated.
- **Exact division:** v0=(10,0), v1=(20,4), v2=(4,12)
  - → 3 start pulses with dividend/divisor 2560/4, 1536/12, 4096/8;
  - slopes 640, −128 (0x1FF80), −512 (0x1FE00); o_flat=000, o_error=0.
- **Rounding:** v0=(0,0), v1=(2,3), v2=(0,6), i.e. edge01 dx=2, dy=3, edge12 dx=−2, dy=3
  - → slope01=171, slope02=0 (dividend 0), slope12=−171 (0x1FF55).
- **Flat edge:** v0=(0,5), v1=(9,5), v2=(3,10)
  - → only 2 start pulses;
  - slope01=0, o_flat=001, slope02=154 (768/5 r3), slope12=−307 (1536/5 r1).
- **Unsorted:** v0 y=7, v1 y=3
  - → o_valid 2 cycles after start; o_error=1; slopes 0; zero o_div_start pulses.
- **Backpressure:** stub divider holds i_div_ready=0 for 5 cycles and returns i_div_valid after 20 cycles
  - → no start pulse during the stall; operands stable until valid; results match the exact-division case.
- **Mid-operation reset:** pulse i_reset_n low while in WAIT on edge 02
  - → all outputs 0 and o_ready=1 immediately;
  - a following start produces the correct results with no stale slope.

Source files
------------

// File: rtl/edge_slope_setup_if.sv
// Divider handshake bundle between edge_slope_setup (master side) and the shared divider (slave).
interface edge_slope_setup_if #(
  parameter int unsigned DIV_WIDTH = 16
) ();
  logic                 div_start;
  logic [DIV_WIDTH-1:0] div_dividend;
  logic [DIV_WIDTH-1:0] div_divisor;
  logic                 div_ready;
  logic                 div_valid;
  logic [DIV_WIDTH-1:0] div_quotient;
  logic [DIV_WIDTH-1:0] div_remainder;

  modport master (output div_start, div_dividend, div_divisor,
                  input  div_ready, div_valid, div_quotient, div_remainder);
  modport slave  (input  div_start, div_dividend, div_divisor,
                  output div_ready, div_valid, div_quotient, div_remainder);
endinterface

// File: rtl/edge_slope_setup.sv
// Triangle setup: signed, rounded inverse slopes dx/dy for edges 01, 02, 12 of a y-sorted
// triangle, computed one division at a time through a shared unsigned divider.
module edge_slope_setup #(
  parameter int unsigned COORD_WIDTH = 8,
  parameter int unsigned FRAC_BITS   = 8,
  parameter int unsigned DIV_WIDTH   = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_start,
  input  logic [COORD_WIDTH-1:0] i_x0,
  input  logic [COORD_WIDTH-1:0] i_y0,
  input  logic [COORD_WIDTH-1:0] i_x1,
  input  logic [COORD_WIDTH-1:0] i_y1,
  input  logic [COORD_WIDTH-1:0] i_x2,
  input  logic [COORD_WIDTH-1:0] i_y2,
  output logic                   o_ready,
  output logic                   o_valid,
  output logic [DIV_WIDTH:0]     o_slope01,
  output logic [DIV_WIDTH:0]     o_slope02,
  output logic [DIV_WIDTH:0]     o_slope12,
  output logic [2:0]             o_flat,
  output logic                   o_error,
  edge_slope_setup_if.master     div_if
);

  typedef enum logic [2:0] {StIdle, StCheck, StIssue, StWait, StDone} state_e;

  state_e                 r_state, w_state;
  logic [1:0]             r_edge, w_edge;
  logic [COORD_WIDTH-1:0] r_x0, r_y0, r_x1, r_y1, r_x2, r_y2;
  logic [DIV_WIDTH:0]     r_slope01, r_slope02, r_slope12;
  logic [2:0]             r_flat;
  logic                   r_error, r_valid, r_div_start;
  logic [DIV_WIDTH-1:0]   r_dividend, r_divisor;

  logic [COORD_WIDTH-1:0] w_xa, w_ya, w_xb, w_yb, w_dx_abs, w_dy;
  logic                   w_dx_neg, w_round;
  logic [DIV_WIDTH-1:0]   w_dividend, w_divisor;
  logic [DIV_WIDTH:0]     w_rem2, w_mag, w_rounded, w_store_slope;
  logic w_valid, w_div_start, w_accept, w_load_ops, w_err_set, w_err_clr;
  logic w_store, w_store_flat, w_advance;

  // Endpoints of the edge currently being set up
  always_comb begin
    unique case (r_edge)
      2'd0:    begin w_xa = r_x0; w_ya = r_y0; w_xb = r_x1; w_yb = r_y1; end
      2'd1:    begin w_xa = r_x0; w_ya = r_y0; w_xb = r_x2; w_yb = r_y2; end
      default: begin w_xa = r_x1; w_ya = r_y1; w_xb = r_x2; w_yb = r_y2; end
    endcase
  end

  assign w_dx_neg   = (w_xb < w_xa);
  assign w_dx_abs   = w_dx_neg ? (w_xa - w_xb) : (w_xb - w_xa);
  assign w_dy       = w_yb - w_ya;
  assign w_dividend = DIV_WIDTH'(w_dx_abs) << FRAC_BITS;
  assign w_divisor  = DIV_WIDTH'(w_dy);

  // Round to nearest: bump the quotient when the remainder is at least half the divisor
  assign w_rem2     = {div_if.div_remainder, 1'b0};
  assign w_round    = (w_rem2 >= {1'b0, r_divisor});
  assign w_mag      = {1'b0, div_if.div_quotient} + (DIV_WIDTH+1)'(w_round);
  assign w_rounded  = w_dx_neg ? -w_mag : w_mag;

  always_comb begin
    w_state       = r_state;
    w_edge        = r_edge;
    w_valid       = 1'b0;
    w_div_start   = 1'b0;
    w_accept      = 1'b0;
    w_load_ops    = 1'b0;
    w_err_set     = 1'b0;
    w_err_clr     = 1'b0;
    w_store       = 1'b0;
    w_store_slope = '0;
    w_store_flat  = 1'b0;
    w_advance     = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_accept = 1'b1;
          w_state  = StCheck;
        end
      end
      StCheck: begin
        if ((r_y0 > r_y1) || (r_y1 > r_y2)) begin
          w_err_set = 1'b1;
          w_valid   = 1'b1;
          w_state   = StDone;
        end else begin
          w_err_clr = 1'b1;
          w_edge    = 2'd0;
          w_state   = StIssue;
        end
      end
      StIssue: begin
        if (w_dy == '0) begin
          w_store      = 1'b1;
          w_store_flat = 1'b1;
          w_advance    = 1'b1;
        end else if (div_if.div_ready) begin
          w_div_start = 1'b1;
          w_load_ops  = 1'b1;
          w_state     = StWait;
        end
      end
      StWait: begin
        if (div_if.div_valid) begin
          w_store       = 1'b1;
          w_store_slope = w_rounded;
          w_advance     = 1'b1;
        end
      end
      StDone:  w_state = StIdle;
      default: w_state = StIdle;
    endcase
    if (w_advance) begin
      if (r_edge == 2'd2) begin
        w_state = StDone;
        w_valid = 1'b1;
      end else begin
        w_edge  = r_edge + 2'd1;
        w_state = StIssue;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_edge      <= '0;
      r_valid     <= 1'b0;
      r_div_start <= 1'b0;
      r_x0        <= '0;
      r_y0        <= '0;
      r_x1        <= '0;
      r_y1        <= '0;
      r_x2        <= '0;
      r_y2        <= '0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_slope01   <= '0;
      r_slope02   <= '0;
      r_slope12   <= '0;
      r_flat      <= '0;
      r_error     <= 1'b0;
    end else begin
      r_edge      <= w_edge;
      r_valid     <= w_valid;
      r_div_start <= w_div_start;
      if (w_accept) begin
        r_x0 <= i_x0;
        r_y0 <= i_y0;
        r_x1 <= i_x1;
        r_y1 <= i_y1;
        r_x2 <= i_x2;
        r_y2 <= i_y2;
      end
      if (w_load_ops) begin
        r_dividend <= w_dividend;
        r_divisor  <= w_divisor;
      end
      if (w_err_set) begin
        r_slope01 <= '0;
        r_slope02 <= '0;
        r_slope12 <= '0;
        r_flat    <= '0;
        r_error   <= 1'b1;
      end
      if (w_err_clr) begin
        r_error <= 1'b0;
      end
      if (w_store) begin
        unique case (r_edge)
          2'd0:    begin r_slope01 <= w_store_slope; r_flat[0] <= w_store_flat; end
          2'd1:    begin r_slope02 <= w_store_slope; r_flat[1] <= w_store_flat; end
          default: begin r_slope12 <= w_store_slope; r_flat[2] <= w_store_flat; end
        endcase
      end
    end
  end

  assign o_ready             = (r_state == StIdle);
  assign o_valid             = r_valid;
  assign o_slope01           = r_slope01;
  assign o_slope02           = r_slope02;
  assign o_slope12           = r_slope12;
  assign o_flat              = r_flat;
  assign o_error             = r_error;
  assign div_if.div_start    = r_div_start;
  assign div_if.div_dividend = r_dividend;
  assign div_if.div_divisor  = r_divisor;

endmodule

// File: tb/tb_edge_slope_setup.sv
// Directed bench for edge_slope_setup with a behavioural divider and an expected-result queue.
module tb_edge_slope_setup;
  localparam int unsigned CW = 8;
  localparam int unsigned FB = 8;
  localparam int unsigned DW = 16;

  typedef struct {
    logic [DW:0] s01;
    logic [DW:0] s02;
    logic [DW:0] s12;
    logic [2:0]  flat;
    logic        err;
    int          starts;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
  logic          ready, valid, err;
  logic [DW:0]   s01, s02, s12;
  logic [2:0]    flat;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  exp_t        exp_q[$];
  logic [31:0] exp_ops[$];
  logic [DW-1:0] cur_dvd = '0, cur_dvs = '0;

  always #5 clk = ~clk;

  edge_slope_setup_if #(.DIV_WIDTH(DW)) dif ();

  edge_slope_setup #(
    .COORD_WIDTH(CW),
    .FRAC_BITS  (FB),
    .DIV_WIDTH  (DW)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .i_start  (start),
    .i_x0     (x0),
    .i_y0     (y0),
    .i_x1     (x1),
    .i_y1     (y1),
    .i_x2     (x2),
    .i_y2     (y2),
    .o_ready  (ready),
    .o_valid  (valid),
    .o_slope01(s01),
    .o_slope02(s02),
    .o_slope12(s12),
    .o_flat   (flat),
    .o_error  (err),
    .div_if   (dif)
  );

  // Behavioural divider: optional ready stall window and programmable result latency
  int unsigned cyc = 0;
  int unsigned stall_until = 0;
  int unsigned latency = 3;
  int unsigned cnt = 0;
  logic        busy = 1'b0;
  logic [DW-1:0] m_q = '0, m_r = '0;

  assign dif.div_ready = !busy && (cyc >= stall_until);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy              <= 1'b0;
      cnt               <= 0;
      dif.div_valid     <= 1'b0;
      dif.div_quotient  <= '0;
      dif.div_remainder <= '0;
    end else begin
      cyc           <= cyc + 1;
      dif.div_valid <= 1'b0;
      if (busy) begin
        if (cnt <= 1) begin
          dif.div_valid     <= 1'b1;
          dif.div_quotient  <= m_q;
          dif.div_remainder <= m_r;
          busy              <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end else if (dif.div_start && dif.div_ready) begin
        m_q  <= (dif.div_divisor == '0) ? '1 : dif.div_dividend / dif.div_divisor;
        m_r  <= (dif.div_divisor == '0) ? '0 : dif.div_dividend % dif.div_divisor;
        busy <= 1'b1;
        cnt  <= latency;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check divider traffic seen there
  task automatic tick();
    logic [31:0] op;
    @(negedge clk);
    if (rst_n && dif.div_start) begin
      n_starts++;
      cur_dvd = dif.div_dividend;
      cur_dvs = dif.div_divisor;
      if (exp_ops.size() == 0) begin
        chk("unexpected div_start", 32'd1, 32'd0);
      end else begin
        op = exp_ops.pop_front();
        chk("div_dividend", 32'(dif.div_dividend), 32'(op[31:16]));
        chk("div_divisor", 32'(dif.div_divisor), 32'(op[15:0]));
      end
    end
    if (rst_n && dif.div_valid) begin
      chk("dividend held", 32'(dif.div_dividend), 32'(cur_dvd));
      chk("divisor held", 32'(dif.div_divisor), 32'(cur_dvs));
    end
  endtask

  task automatic drive(input logic [CW-1:0] a0, b0, a1, b1, a2, b2);
    x0 = a0; y0 = b0; x1 = a1; y1 = b1; x2 = a2; y2 = b2;
  endtask

  task automatic check_results(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({name, " scoreboard empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({name, " slope01"}, 32'(s01), 32'(e.s01));
    chk({name, " slope02"}, 32'(s02), 32'(e.s02));
    chk({name, " slope12"}, 32'(s12), 32'(e.s12));
    chk({name, " flat"}, 32'(flat), 32'(e.flat));
    chk({name, " error"}, 32'(err), 32'(e.err));
  endtask

  task automatic run_case(input string name, input logic [CW-1:0] a0, b0, a1, b1, a2, b2,
                          input logic [DW:0] e01, e02, e12, input logic [2:0] ef,
                          input int nstart, input logic [31:0] op0, op1, op2,
                          input int stall_ticks);
    exp_t e;
    int   base;
    int   k;
    e.s01 = e01; e.s02 = e02; e.s12 = e12; e.flat = ef; e.err = 1'b0; e.starts = nstart;
    exp_q.push_back(e);
    if (nstart > 0) exp_ops.push_back(op0);
    if (nstart > 1) exp_ops.push_back(op1);
    if (nstart > 2) exp_ops.push_back(op2);
    base = n_starts;
    drive(a0, b0, a1, b1, a2, b2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, " ready low"}, 32'(ready), 32'd0);
    for (int i = 0; i < stall_ticks; i++) begin
      chk({name, " no start in stall"}, 32'(dif.div_start), 32'd0);
      tick();
    end
    k = 0;
    while (valid !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    if (valid !== 1'b1) begin
      chk({name, " valid timeout"}, 32'd0, 32'd1);
    end else begin
      check_results(name);
      chk({name, " start count"}, 32'(n_starts - base), 32'(exp_q.size() == 0 ? nstart : -1));
      tick();
      chk({name, " valid one cycle"}, 32'(valid), 32'd0);
      chk({name, " ready back"}, 32'(ready), 32'd1);
    end
  endtask

  initial begin
    int   base;
    int   k;
    exp_t e;

    #12;
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset slope01", 32'(s01), 32'd0);
    chk("reset flat", 32'(flat), 32'd0);
    chk("reset error", 32'(err), 32'd0);
    chk("reset div_start", 32'(dif.div_start), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_case("exact", 8'd10, 8'd0, 8'd20, 8'd4, 8'd4, 8'd12,
             17'd640, 17'h1FF80, 17'h1FE00, 3'b000, 3,
             {16'd2560, 16'd4}, {16'd1536, 16'd12}, {16'd4096, 16'd8}, 0);

    run_case("round", 8'd0, 8'd0, 8'd2, 8'd3, 8'd0, 8'd6,
             17'd171, 17'd0, 17'h1FF55, 3'b000, 3,
             {16'd512, 16'd3}, {16'd0, 16'd6}, {16'd512, 16'd3}, 0);

    run_case("flat", 8'd0, 8'd5, 8'd9, 8'd5, 8'd3, 8'd10,
             17'd0, 17'd154, 17'h1FECD, 3'b001, 2,
             {16'd768, 16'd5}, {16'd1536, 16'd5}, 32'd0, 0);

    // Unsorted vertices: no divisions, o_valid two cycles after acceptance
    e.s01 = '0; e.s02 = '0; e.s12 = '0; e.flat = 3'b000; e.err = 1'b1; e.starts = 0;
    exp_q.push_back(e);
    base = n_starts;
    drive(8'd1, 8'd7, 8'd2, 8'd3, 8'd3, 8'd9);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("unsorted ready low", 32'(ready), 32'd0);
    chk("unsorted valid early", 32'(valid), 32'd0);
    tick();
    chk("unsorted valid", 32'(valid), 32'd1);
    check_results("unsorted");
    tick();
    chk("unsorted valid drop", 32'(valid), 32'd0);
    chk("unsorted ready back", 32'(ready), 32'd1);
    chk("unsorted starts", 32'(n_starts - base), 32'd0);

    // Divider backpressure and long latency
    latency = 20;
    stall_until = cyc + 5;
    run_case("backpressure", 8'd10, 8'd0, 8'd20, 8'd4, 8'd4, 8'd12,
             17'd640, 17'h1FF80, 17'h1FE00, 3'b000, 3,
             {16'd2560, 16'd4}, {16'd1536, 16'd12}, {16'd4096, 16'd8}, 5);
    latency = 3;

    // Reset while the edge-02 division is outstanding
    latency = 6;
    exp_ops.push_back({16'd2560, 16'd4});
    exp_ops.push_back({16'd1536, 16'd12});
    exp_ops.push_back({16'd4096, 16'd8});
    base = n_starts;
    drive(8'd10, 8'd0, 8'd20, 8'd4, 8'd4, 8'd12);
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (n_starts < base + 2 && k < 200) begin
      tick();
      k++;
    end
    chk("midreset second start seen", 32'(n_starts - base), 32'd2);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midreset ready", 32'(ready), 32'd1);
    chk("midreset valid", 32'(valid), 32'd0);
    chk("midreset slope01", 32'(s01), 32'd0);
    chk("midreset slope02", 32'(s02), 32'd0);
    chk("midreset flat", 32'(flat), 32'd0);
    chk("midreset error", 32'(err), 32'd0);
    chk("midreset dividend", 32'(dif.div_dividend), 32'd0);
    chk("midreset divisor", 32'(dif.div_divisor), 32'd0);
    exp_ops.delete();
    tick();
    rst_n = 1'b1;
    latency = 3;
    tick();

    run_case("after reset", 8'd0, 8'd0, 8'd2, 8'd3, 8'd0, 8'd6,
             17'd171, 17'd0, 17'h1FF55, 3'b000, 3,
             {16'd512, 16'd3}, {16'd0, 16'd6}, {16'd512, 16'd3}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
